quad_decoder: RTL

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/quad_pkg.sv | 28 ++
 rtl/quad_debounce.sv | 43 ++++
 rtl/quad_decoder.sv | 118 +++++++++++
 3 files changed

// File: rtl/quad_pkg.sv
// Shared quadrature decoder definitions.
// Command encoding is common with the downstream up/down counter.
package quad_pkg;

  localparam logic [1:0] CTRL_HOLD = 2'b00;
  localparam logic [1:0] CTRL_INC  = 2'b01;
  localparam logic [1:0] CTRL_DEC  = 2'b10;

  typedef enum logic {
    ST_SETTLE,
    ST_RUN
  } dec_state_e;

  // Forward Gray order: 00 -> 01 -> 11 -> 10 -> 00
  function automatic logic [1:0] fwd_next(
    input logic [1:0] ab
  );
    logic [1:0] nx;
    case (ab)
      2'b00:   nx = 2'b01;
      2'b01:   nx = 2'b11;
      2'b11:   nx = 2'b10;
      default: nx = 2'b00;
    endcase
    return nx;
  endfunction

endpackage

// File: rtl/quad_debounce.sv
// One encoder channel: 2-flop synchronizer followed by
// a run-length debouncer with a saturating run counter.
import quad_pkg::*;

module quad_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  localparam logic [7:0] LAST = 8'(DEB_CYCLES - 1);

  logic       r_s1;
  logic       r_s2;
  logic       r_q;
  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_q   <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      if (r_s2 == r_q) begin
        r_cnt <= '0;
      end else if (r_cnt >= LAST) begin
        r_q   <= r_s2;
        r_cnt <= '0;
      end else if (r_cnt != 8'hFF) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: debounced A/B into a signed sub-step
// accumulator emitting one INC/DEC pulse per DIV sub-steps.
import quad_pkg::*;

module quad_decoder #(
  parameter int DEB_CYCLES = 4,
  parameter int DIV        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_a,
  input  logic       enc_b,
  output logic [1:0] control,
  output logic       err
);

  localparam logic signed [3:0] ACC_MAX = 4'(DIV);
  localparam logic signed [3:0] ACC_MIN = -ACC_MAX;
  localparam logic [8:0] SETTLE_LAST = 9'(DEB_CYCLES + 3);

  logic w_a;
  logic w_b;

  quad_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
    .clk (clk),
    .rst (rst),
    .i_d (enc_a),
    .o_q (w_a)
  );

  quad_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
    .clk (clk),
    .rst (rst),
    .i_d (enc_b),
    .o_q (w_b)
  );

  dec_state_e        r_state;
  dec_state_e        w_state_n;
  logic [8:0]        r_settle;
  logic [8:0]        w_settle_n;
  logic [1:0]        r_cur;
  logic [1:0]        r_prev;
  logic signed [3:0] r_acc;
  logic signed [3:0] w_acc_n;
  logic signed [3:0] w_step;
  logic signed [3:0] w_sum;
  logic              w_ill;
  logic [1:0]        w_ctrl_n;
  logic              w_err_n;

  always_comb begin
    w_step = '0;
    w_ill  = 1'b0;
    unique case (1'b1)
      (r_prev == r_cur):           ;
      (&(r_prev ^ r_cur)):         w_ill  = 1'b1;
      (r_cur == fwd_next(r_prev)): w_step = 4'sd1;
      default:                     w_step = -4'sd1;
    endcase
  end

  assign w_sum = r_acc + w_step;

  // Settling window hides the reset-to-real-level jump of both channels
  always_comb begin
    w_state_n  = r_state;
    w_settle_n = r_settle;
    w_acc_n    = r_acc;
    w_ctrl_n   = CTRL_HOLD;
    w_err_n    = 1'b0;
    case (r_state)
      ST_SETTLE: begin
        w_acc_n    = '0;
        w_settle_n = r_settle + 9'd1;
        if (r_settle == SETTLE_LAST) begin
          w_state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_ill) begin
          w_err_n = 1'b1;
          w_acc_n = '0;
        end else if (w_sum == ACC_MAX) begin
          w_ctrl_n = CTRL_INC;
          w_acc_n  = '0;
        end else if (w_sum == ACC_MIN) begin
          w_ctrl_n = CTRL_DEC;
          w_acc_n  = '0;
        end else begin
          w_acc_n = w_sum;
        end
      end
      default: w_state_n = ST_SETTLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_SETTLE;
      r_settle <= '0;
      r_cur    <= '0;
      r_prev   <= '0;
      r_acc    <= '0;
      control  <= CTRL_HOLD;
      err      <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_settle <= w_settle_n;
      r_cur    <= {w_a, w_b};
      r_prev   <= r_cur;
      r_acc    <= w_acc_n;
      control  <= w_ctrl_n;
      err      <= w_err_n;
    end
  end

endmodule
